// File: rtl/stopwatch_pkg.sv
// Shared types, field limits and count-increment helpers for the stopwatch sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LAP    = 2'd2,
    PAUSED = 2'd3
  } sw_state_e;

  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int MS_W  = 10;

  localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  typedef struct packed {
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [MS_W-1:0]  ms;
  } sw_count_t;

  localparam sw_count_t COUNT_ZERO = {6'd0, 6'd0, 10'd0};

  // Advance a min:sec:ms count by one millisecond, rolling minutes over after max_min.
  function automatic sw_count_t count_inc(input sw_count_t c, input logic [MIN_W-1:0] max_min);
    sw_count_t n;
    n = c;
    if (c.ms == MS_MAX) begin
      n.ms = 10'd0;
      if (c.sec == SEC_MAX) begin
        n.sec = 6'd0;
        if (c.min == max_min) begin
          n.min = 6'd0;
        end else begin
          n.min = c.min + 6'd1;
        end
      end else begin
        n.sec = c.sec + 6'd1;
      end
    end else begin
      n.ms = c.ms + 10'd1;
    end
    return n;
  endfunction

  function automatic logic count_at_max(input sw_count_t c, input logic [MIN_W-1:0] max_min);
    return (c.ms == MS_MAX) && (c.sec == SEC_MAX) && (c.min == max_min);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button-pulse and display bundle between the debouncers, the stopwatch and the display mux.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic             start_stop_p;
  logic             lap_p;
  logic             clear_p;
  logic [MIN_W-1:0] disp_min;
  logic [SEC_W-1:0] disp_sec;
  logic [MS_W-1:0]  disp_ms;
  logic             running;
  logic             lap_active;
  logic             wrap_p;

  modport master (
    output start_stop_p, lap_p, clear_p,
    input  disp_min, disp_sec, disp_ms, running, lap_active, wrap_p
  );

  modport slave (
    input  start_stop_p, lap_p, clear_p,
    output disp_min, disp_sec, disp_ms, running, lap_active, wrap_p
  );

endinterface

// File: rtl/stopwatch_ctrl_ms_tick_gen.sv
// Millisecond prescaler: counts clk_27Mhz cycles while enabled and flags the last cycle of each ms.
module ms_tick_gen #(
  parameter int DIV = 27_000
) (
  input  logic clk_27Mhz,
  input  logic rst_n,
  input  logic en,
  input  logic zero,
  output logic tick
);

  localparam int               CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] presc_r;

  assign tick = en && (presc_r == LAST);

  // Prescaler holds its phase while disabled so a resumed run loses no partial millisecond.
  always_ff @(posedge clk_27Mhz or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {CNT_W{1'b0}};
    end else if (zero) begin
      presc_r <= {CNT_W{1'b0}};
    end else if (tick) begin
      presc_r <= {CNT_W{1'b0}};
    end else if (en) begin
      presc_r <= presc_r + CNT_W'(1);
    end else begin
      presc_r <= presc_r;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/lap/clear control over a min:sec:ms count driven by a 1 ms tick.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV     = 27_000,
  parameter int MAX_MIN = 59
) (
  input  logic              clk_27Mhz,
  input  logic              rst_n,
  stopwatch_ctrl_if.slave   sw
);

  localparam logic [MIN_W-1:0] MAX_MIN_C = MIN_W'(MAX_MIN);

  sw_state_e state_r, state_s;
  sw_count_t live_r, live_s;
  sw_count_t held_r, held_s;
  sw_count_t disp_r, disp_s;
  logic      running_r, running_s;
  logic      lap_active_r, lap_active_s;
  logic      wrap_r, wrap_s;
  logic      presc_en_s, presc_zero_s, tick_s;

  ms_tick_gen #(.DIV(DIV)) u_ms_tick_gen (
    .clk_27Mhz (clk_27Mhz),
    .rst_n     (rst_n),
    .en        (presc_en_s),
    .zero      (presc_zero_s),
    .tick      (tick_s)
  );

  // State register.
  always_ff @(posedge clk_27Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: clear outranks start/stop, which outranks lap; events invalid in a state fall through.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sw.start_stop_p) state_s = RUN;
        else                 state_s = IDLE;
      end
      RUN: begin
        if (sw.start_stop_p) state_s = PAUSED;
        else if (sw.lap_p)   state_s = LAP;
        else                 state_s = RUN;
      end
      LAP: begin
        if (sw.start_stop_p) state_s = PAUSED;
        else if (sw.lap_p)   state_s = RUN;
        else                 state_s = LAP;
      end
      PAUSED: begin
        if (sw.clear_p)           state_s = IDLE;
        else if (sw.start_stop_p) state_s = RUN;
        else                      state_s = PAUSED;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath and output next values; the lap snapshot takes the pre-tick live count.
  always_comb begin
    presc_en_s   = (state_r == RUN) || (state_r == LAP);
    presc_zero_s = ((state_r == IDLE) && sw.start_stop_p) || ((state_r == PAUSED) && sw.clear_p);

    if ((state_r == PAUSED) && (state_s == IDLE)) begin
      live_s = COUNT_ZERO;
    end else if (tick_s) begin
      live_s = count_inc(live_r, MAX_MIN_C);
    end else begin
      live_s = live_r;
    end

    if ((state_r == RUN) && (state_s == LAP)) begin
      held_s = live_r;
    end else begin
      held_s = held_r;
    end

    if (state_s == LAP) begin
      disp_s = held_s;
    end else begin
      disp_s = live_s;
    end

    wrap_s       = tick_s && count_at_max(live_r, MAX_MIN_C);
    running_s    = (state_s == RUN) || (state_s == LAP);
    lap_active_s = (state_s == LAP);
  end

  // Count and output registers.
  always_ff @(posedge clk_27Mhz or negedge rst_n) begin
    if (!rst_n) begin
      live_r       <= COUNT_ZERO;
      held_r       <= COUNT_ZERO;
      disp_r       <= COUNT_ZERO;
      running_r    <= 1'b0;
      lap_active_r <= 1'b0;
      wrap_r       <= 1'b0;
    end else begin
      live_r       <= live_s;
      held_r       <= held_s;
      disp_r       <= disp_s;
      running_r    <= running_s;
      lap_active_r <= lap_active_s;
      wrap_r       <= wrap_s;
    end
  end

  assign sw.disp_min   = disp_r.min;
  assign sw.disp_sec   = disp_r.sec;
  assign sw.disp_ms    = disp_r.ms;
  assign sw.running    = running_r;
  assign sw.lap_active = lap_active_r;
  assign sw.wrap_p     = wrap_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed phases plus random pulses against an elapsed-time model.
module tb_stopwatch_ctrl;

  localparam int    DIV     = 4;
  localparam int    MAX_MIN = 59;
  localparam longint PERIOD = longint'(MAX_MIN + 1) * 60000;

  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSED = 3;

  logic clk = 1'b0;
  logic clk_w = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;
  always #1 clk_w = ~clk_w;

  stopwatch_ctrl_if sw ();
  stopwatch_ctrl_if w_if ();

  stopwatch_ctrl #(.DIV(DIV), .MAX_MIN(MAX_MIN)) dut (
    .clk_27Mhz (clk),
    .rst_n     (rst_n),
    .sw        (sw)
  );

  stopwatch_ctrl #(.DIV(2), .MAX_MIN(0)) dut_wrap (
    .clk_27Mhz (clk_w),
    .rst_n     (rst_n),
    .sw        (w_if)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: elapsed counting cycles, ms = cycles / DIV.
  int     mode;
  longint run_cycles;
  longint held_ms;
  bit     exp_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode       = M_IDLE;
    run_cycles = 0;
    held_ms    = 0;
    exp_wrap   = 1'b0;
  endtask

  task automatic model_update(input bit s, input bit l, input bit c);
    bit     counting;
    longint pre_ms;
    counting = (mode == M_RUN) || (mode == M_LAP);
    pre_ms   = run_cycles / DIV;
    if (counting) run_cycles++;
    exp_wrap = counting && (run_cycles % DIV == 0) && ((run_cycles / DIV) % PERIOD == 0);
    if (c && mode == M_PAUSED) begin
      mode = M_IDLE;
      run_cycles = 0;
    end else if (s) begin
      if (mode == M_IDLE) begin
        mode = M_RUN;
        run_cycles = 0;
      end else if (mode == M_PAUSED) mode = M_RUN;
      else mode = M_PAUSED;
    end else if (l && mode == M_RUN) begin
      held_ms = pre_ms;
      mode = M_LAP;
    end else if (l && mode == M_LAP) begin
      mode = M_RUN;
    end
  endtask

  function automatic longint model_disp();
    longint t;
    t = (mode == M_LAP) ? held_ms : (run_cycles / DIV);
    return t % PERIOD;
  endfunction

  task automatic check_all(input string tag);
    longint t;
    t = model_disp();
    chk({tag, ".min"}, 32'(sw.disp_min), 32'(t / 60000));
    chk({tag, ".sec"}, 32'(sw.disp_sec), 32'((t / 1000) % 60));
    chk({tag, ".ms"}, 32'(sw.disp_ms), 32'(t % 1000));
    chk({tag, ".running"}, 32'(sw.running), 32'((mode == M_RUN) || (mode == M_LAP)));
    chk({tag, ".lap"}, 32'(sw.lap_active), 32'(mode == M_LAP));
    chk({tag, ".wrap"}, 32'(sw.wrap_p), 32'(exp_wrap));
  endtask

  task automatic step(input bit s, input bit l, input bit c, input string tag);
    sw.start_stop_p = s;
    sw.lap_p        = l;
    sw.clear_p      = c;
    @(posedge clk);
    model_update(s, l, c);
    #1;
    sw.start_stop_p = 1'b0;
    sw.lap_p        = 1'b0;
    sw.clear_p      = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [9:0] saved_ms;
    int guard, nwrap, wrap_at;
    sw.start_stop_p = 1'b0; sw.lap_p = 1'b0; sw.clear_p = 1'b0;
    w_if.start_stop_p = 1'b0; w_if.lap_p = 1'b0; w_if.clear_p = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    repeat (100) step(1'b0, 1'b0, 1'b0, "idle");

    step(1'b1, 1'b0, 1'b0, "start");
    chk("start_running", 32'(sw.running), 32'd1);
    repeat (3) step(1'b0, 1'b0, 1'b0, "first_tick");
    chk("ms_before_tick", 32'(sw.disp_ms), 32'd0);
    step(1'b0, 1'b0, 1'b0, "first_tick");
    chk("ms_first", 32'(sw.disp_ms), 32'd1);
    repeat (996) step(1'b0, 1'b0, 1'b0, "count");
    chk("ms_250", 32'(sw.disp_ms), 32'd250);

    // Pause once the prescaler has advanced twice into the current millisecond.
    guard = 0;
    while ((run_cycles % DIV) != 1 && guard < 8) begin
      step(1'b0, 1'b0, 1'b0, "align");
      guard++;
    end
    step(1'b1, 1'b0, 1'b0, "pause");
    saved_ms = sw.disp_ms;
    repeat (50) step(1'b0, 1'b0, 1'b0, "paused");
    chk("pause_hold", 32'(sw.disp_ms), 32'(saved_ms));
    chk("pause_running", 32'(sw.running), 32'd0);
    step(1'b1, 1'b0, 1'b0, "resume");
    step(1'b0, 1'b0, 1'b0, "resume1");
    chk("resume_no_tick", 32'(sw.disp_ms), 32'(saved_ms));
    step(1'b0, 1'b0, 1'b0, "resume2");
    chk("resume_tick_2cyc", 32'(sw.disp_ms), 32'(saved_ms + 10'd1));

    step(1'b0, 1'b0, 1'b1, "clear_in_run");
    chk("clear_run_ignored", 32'(sw.running), 32'd1);
    repeat (10) step(1'b0, 1'b0, 1'b0, "after_clear_run");

    step(1'b1, 1'b0, 1'b0, "pause2");
    step(1'b1, 1'b0, 1'b1, "clear_and_start");
    chk("clear_wins_ms", 32'(sw.disp_ms), 32'd0);
    chk("clear_wins_run", 32'(sw.running), 32'd0);

    step(1'b1, 1'b0, 1'b0, "restart");
    guard = 0;
    while (model_disp() != 100 && guard < 1000) begin
      step(1'b0, 1'b0, 1'b0, "to_100");
      guard++;
    end
    chk("reach_100", 32'(sw.disp_ms), 32'd100);
    step(1'b0, 1'b1, 1'b0, "lap_on");
    repeat (400) step(1'b0, 1'b0, 1'b0, "lap_hold");
    chk("lap_frozen", 32'(sw.disp_ms), 32'd100);
    step(1'b0, 1'b1, 1'b0, "lap_off");
    chk("lap_release_ms", 32'(sw.disp_ms), 32'd200);
    chk("lap_release_run", 32'(sw.running), 32'd1);

    repeat (3000) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 2, (r >= 2) && (r < 5), ((r >= 5) && (r < 8)) || (r == 99), "rand");
      if (r == 99) step(1'b1, 1'b1, 1'b1, "rand_all");
    end

    // Asynchronous reset in mid-cycle.
    if (mode == M_IDLE) step(1'b1, 1'b0, 1'b0, "pre_rst_start");
    repeat (20) step(1'b0, 1'b0, 1'b0, "pre_rst");
    @(posedge clk);
    model_update(1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) step(1'b0, 1'b0, 1'b0, "post_rst_idle");
    step(1'b1, 1'b0, 1'b0, "post_rst_start");
    repeat (20) step(1'b0, 1'b0, 1'b0, "post_rst_run");

    // Wrap at MAX_MIN=0 on the second instance.
    @(posedge clk_w);
    #1;
    w_if.start_stop_p = 1'b1;
    @(posedge clk_w);
    #1;
    w_if.start_stop_p = 1'b0;
    nwrap = 0;
    wrap_at = -1;
    for (int j = 1; j <= 121000; j++) begin
      @(posedge clk_w);
      #1;
      if (j == 119999) begin
        chk("wrap_pre_min", 32'(w_if.disp_min), 32'd0);
        chk("wrap_pre_sec", 32'(w_if.disp_sec), 32'd59);
        chk("wrap_pre_ms", 32'(w_if.disp_ms), 32'd999);
      end
      if (w_if.wrap_p === 1'b1) begin
        nwrap++;
        wrap_at = j;
        chk("wrap_zero_min", 32'(w_if.disp_min), 32'd0);
        chk("wrap_zero_sec", 32'(w_if.disp_sec), 32'd0);
        chk("wrap_zero_ms", 32'(w_if.disp_ms), 32'd0);
      end
    end
    chk("wrap_count", 32'(nwrap), 32'd1);
    chk("wrap_cycle", 32'(wrap_at), 32'd120000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Stopwatch sequencer for the FPWW watch face.
- Owns the millisecond prescaler that divides clk_27Mhz into a 1 ms enable, and gates that prescaler on and off from debounced button pulses.
- Keeps a min:sec:ms count and supports start/stop, lap-freeze and clear.
- Sits between the button debouncers and the 7-segment display mux.

Parameters:
- DIV, 27_000, clk_27Mhz cycles per 1 ms tick. Must be >= 2. The bench overrides it to 4.
- MAX_MIN, 59, minute value at which the count wraps.

Ports:
- clk_27Mhz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_stop_p  in  1  one-cycle pulse; toggles run/pause.
- lap_p  in  1  one-cycle pulse; freezes or releases the display.
- clear_p  in  1  one-cycle pulse; zeroes the count (PAUSED only).
- disp_min  out  6  displayed minutes, 0..MAX_MIN.
- disp_sec  out  6  displayed seconds, 0..59.
- disp_ms  out  10  displayed milliseconds, 0..999.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high while the display is frozen.
- wrap_p  out  1  one-cycle pulse when MAX_MIN:59.999 rolls over to 0:00.000.

Behaviour:
- Async reset values:
  - state = IDLE; prescaler = 0; live count = 0; held count = 0.
  - All outputs 0.
- States: IDLE, RUN, LAP, PAUSED.
- Event priority within one cycle: clear_p > start_stop_p > lap_p. Only the highest-priority valid event acts; the others are ignored.
- Transitions:
  - IDLE, start_stop_p -> RUN. Prescaler forced to 0.
  - RUN, start_stop_p -> PAUSED.
  - RUN, lap_p -> LAP. The held count copies the live count as it stands in that cycle, before any tick increment in the same cycle.
  - LAP, lap_p -> RUN.
  - LAP, start_stop_p -> PAUSED. The display switches back to the live count.
  - PAUSED, start_stop_p -> RUN. The prescaler resumes from its retained value, so no partial millisecond is lost.
  - PAUSED, clear_p -> IDLE. Prescaler and live count set to 0.
  - clear_p in IDLE, RUN or LAP: ignored.
  - lap_p in IDLE or PAUSED: ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and LAP; holds its value otherwise.
  - tick = (prescaler == DIV-1) while counting; the prescaler wraps to 0 on tick.
- Live count update on tick:
  - ms increments.
  - At 999: ms -> 0 and sec increments.
  - At sec 59: sec -> 0 and min increments.
  - At min MAX_MIN: min -> 0 and wrap_p = 1 in the following cycle.
  - All fields use plain binary with explicit compares; no modulo operators.
- Display:
  - disp_* show the held count in LAP and the live count in every other state.
  - All outputs are registered.
- Latency:
  - start_stop_p at cycle N -> running = 1 at N+1.
  - First tick at cycle N+DIV; disp_ms = 1 at N+DIV+1.
- Reset asserted mid-operation: all state clears immediately (asynchronous). After deassertion the block is in IDLE.

Decomposition:
- Package stopwatch_pkg:
  - State enum {IDLE, RUN, LAP, PAUSED}.
  - Constants MS_MAX = 999 and SEC_MAX = 59.
  - Field width localparams (6/6/10).
- Sub-module ms_tick_gen:
  - Ports: clk_27Mhz, rst_n, en, zero, tick; parameter DIV.
  - Holds the prescaler; zero has priority over en.
  - Instantiated once in stopwatch_ctrl.

Test Plan (DIV=4):
- Reset then idle: rst_n low then high, no pulses for 100 cycles -> all outputs 0, state IDLE.
- Start and count: start_stop_p at cycle 10 -> running = 1 at cycle 11; disp_ms = 1 at cycle 15; disp_ms = 250 at cycle 1011.
- Pause and resume: pause after 2 prescaler counts, wait 50 cycles, resume -> next tick arrives 2 cycles after resume, not 4; disp_ms steady during the pause.
- Lap: lap_p at disp_ms = 100 -> disp_ms stays 100 for 400 cycles; second lap_p -> disp_ms jumps to 200, still counting.
- Wrap: MAX_MIN = 0, run 60000 ticks -> wrap_p pulses exactly once; disp_* = 0:00.000 the next cycle.
- Simultaneous events and clear guarding:
  - In PAUSED, clear_p with start_stop_p in the same cycle -> IDLE with count 0.
  - In RUN, clear_p alone -> ignored; count continues.
